uart_wb_master: RTL

Host-driven Wishbone bus master reached over a dedicated 8N1 serial line. It decodes binary read/write command frames from a PC and issues single 32-bit Wishbone cycles. It then returns the read data or a status byte on the same line. It plugs into a free master port of the wb_conbus_top interconnect, for example m2. This gives debug access to bram, ddr, uart and timer address space without CPU involvement.

---
 rtl/uart_wb_master_if.sv | 24 ++
 rtl/uart_wb_master.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_master_if.sv
// Wishbone master bundle for the serial debug bridge.
// Signal names carry the master's point of view (_o driven by the master).
interface uart_wb_master_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );
endinterface

// File: rtl/uart_wb_master.sv
// Serial-to-Wishbone debug master: 8N1 command frames in, single 32-bit
// bus cycles out, read data or a status byte returned on the same line.
module uart_wb_master #(
  parameter int clk_freq      = 50000000,
  parameter int baud          = 115200,
  parameter int wb_timeout    = 65535,
  parameter int frame_timeout = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             uart_rxd,
  output logic             uart_txd,
  output logic             busy,
  uart_wb_master_if.master wb
);

  localparam int DIV   = clk_freq / baud;
  localparam int HALF  = (DIV / 2 > 0) ? DIV / 2 : 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int WB_W  = $clog2(wb_timeout + 1);
  localparam int FT_W  = $clog2(frame_timeout + 1);

  localparam logic [7:0] CMD_RD = 8'h01;
  localparam logic [7:0] CMD_WR = 8'h02;
  localparam logic [7:0] RSP_OK = 8'h06;
  localparam logic [7:0] RSP_NG = 8'h15;

  // ---------------------------------------------------------------- receiver
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

  logic             rxd_s1_q, rxd_s2_q, rxd_prev_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_ferr_q, rx_ferr_d;
  logic             rx_active;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_s1_q   <= uart_rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
    end
  end

  // Receiver bit timing: glitch check at half a bit, then one sample per bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rxd_prev_q && !rxd_s2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == DIV_W'(HALF - 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_s2_q ? RX_IDLE : RX_BITS;
        end
      end
      RX_BITS: begin
        if (rx_cnt_q == DIV_W'(DIV - 1)) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rxd_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == DIV_W'(DIV - 1)) begin
          rx_cnt_d   = '0;
          rx_valid_d = rxd_s2_q;
          rx_ferr_d  = !rxd_s2_q;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // A byte in flight keeps the inter-byte timeout from counting.
  assign rx_active = (rx_state_q != RX_IDLE);

  // ------------------------------------------------- parser / bus / transmit
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_BUS, P_RESP} p_state_t;

  p_state_t         state_q, state_d;
  logic             is_wr_q, is_wr_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [23:0]      sh_q, sh_d;
  logic [31:0]      adr_hold_q, adr_hold_d;
  logic [FT_W-1:0]  frame_tmr_q, frame_tmr_d;
  logic [WB_W-1:0]  wb_tmr_q, wb_tmr_d;
  logic [31:0]      wb_adr_q, wb_adr_d;
  logic [31:0]      wb_dat_q, wb_dat_d;
  logic [3:0]       wb_sel_q, wb_sel_d;
  logic             wb_we_q, wb_we_d;
  logic             wb_cyc_q, wb_cyc_d;
  logic             wb_stb_q, wb_stb_d;
  logic [23:0]      resp_sh_q, resp_sh_d;
  logic [1:0]       resp_left_q, resp_left_d;
  logic [8:0]       tx_rest_q, tx_rest_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             go_bus;
  logic             load_tx;
  logic [7:0]       load_byte;

  // Frame parsing, the single Wishbone cycle and response serialisation.
  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    byte_cnt_d  = byte_cnt_q;
    sh_d        = sh_q;
    adr_hold_d  = adr_hold_q;
    frame_tmr_d = frame_tmr_q;
    wb_tmr_d    = wb_tmr_q;
    wb_adr_d    = wb_adr_q;
    wb_dat_d    = wb_dat_q;
    wb_sel_d    = wb_sel_q;
    wb_we_d     = wb_we_q;
    wb_cyc_d    = wb_cyc_q;
    wb_stb_d    = wb_stb_q;
    resp_sh_d   = resp_sh_q;
    resp_left_d = resp_left_q;
    tx_rest_d   = tx_rest_q;
    tx_bit_d    = tx_bit_q;
    tx_cnt_d    = tx_cnt_q;
    txd_d       = txd_q;
    busy_d      = busy_q;
    go_bus      = 1'b0;
    load_tx     = 1'b0;
    load_byte   = RSP_NG;

    case (state_q)
      P_IDLE: begin
        if (rx_valid_q && (rx_sh_q == CMD_RD || rx_sh_q == CMD_WR)) begin
          is_wr_d     = (rx_sh_q == CMD_WR);
          byte_cnt_d  = '0;
          frame_tmr_d = '0;
          busy_d      = 1'b1;
          state_d     = P_ADDR;
        end
      end
      P_ADDR, P_DATA: begin
        if (rx_ferr_q) begin
          state_d = P_IDLE;
          busy_d  = 1'b0;
        end else if (rx_valid_q) begin
          frame_tmr_d = '0;
          sh_d        = {sh_q[15:0], rx_sh_q};
          byte_cnt_d  = byte_cnt_q + 1'b1;
          if (byte_cnt_q == 2'd3) begin
            if (state_q == P_DATA) begin
              wb_adr_d = adr_hold_q;
              wb_dat_d = {sh_q, rx_sh_q};
              go_bus   = 1'b1;
            end else if (is_wr_q) begin
              adr_hold_d = {sh_q, rx_sh_q};
              state_d    = P_DATA;
            end else begin
              wb_adr_d = {sh_q, rx_sh_q};
              go_bus   = 1'b1;
            end
          end
        end else if (rx_active) begin
          frame_tmr_d = '0;
        end else if (frame_tmr_q == FT_W'(frame_timeout)) begin
          state_d = P_IDLE;
          busy_d  = 1'b0;
        end else begin
          frame_tmr_d = frame_tmr_q + 1'b1;
        end
      end
      P_BUS: begin
        // ack has priority when several terminations arrive together.
        if (wb.wb_ack_i) begin
          load_tx = 1'b1;
          if (is_wr_q) begin
            load_byte   = RSP_OK;
            resp_left_d = 2'd0;
          end else begin
            load_byte   = wb.wb_dat_i[31:24];
            resp_sh_d   = wb.wb_dat_i[23:0];
            resp_left_d = 2'd3;
          end
        end else if (wb.wb_err_i || wb.wb_rty_i ||
                     wb_tmr_q == WB_W'(wb_timeout - 1)) begin
          load_tx     = 1'b1;
          load_byte   = RSP_NG;
          resp_left_d = 2'd0;
        end else begin
          wb_tmr_d = wb_tmr_q + 1'b1;
        end
        if (load_tx) begin
          wb_cyc_d = 1'b0;
          wb_stb_d = 1'b0;
          wb_we_d  = 1'b0;
          wb_sel_d = 4'h0;
          state_d  = P_RESP;
        end
      end
      P_RESP: begin
        if (tx_cnt_q == DIV_W'(DIV - 1)) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            // Next byte's start bit follows the stop bit with no idle gap.
            if (resp_left_q != 2'd0) begin
              load_tx     = 1'b1;
              load_byte   = resp_sh_q[23:16];
              resp_sh_d   = {resp_sh_q[15:0], 8'h00};
              resp_left_d = resp_left_q - 1'b1;
            end else begin
              txd_d   = 1'b1;
              busy_d  = 1'b0;
              state_d = P_IDLE;
            end
          end else begin
            tx_bit_d  = tx_bit_q + 1'b1;
            txd_d     = tx_rest_q[0];
            tx_rest_d = {1'b1, tx_rest_q[8:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = P_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (go_bus) begin
      wb_cyc_d = 1'b1;
      wb_stb_d = 1'b1;
      wb_sel_d = 4'hF;
      wb_we_d  = is_wr_q;
      wb_tmr_d = '0;
      state_d  = P_BUS;
    end
    if (load_tx) begin
      txd_d     = 1'b0;
      tx_rest_d = {1'b1, load_byte};
      tx_bit_d  = '0;
      tx_cnt_d  = '0;
    end
  end

  // Parser, bus and transmitter registers; reset kills cyc/stb and txd at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= P_IDLE;
      is_wr_q     <= 1'b0;
      byte_cnt_q  <= '0;
      sh_q        <= '0;
      adr_hold_q  <= '0;
      frame_tmr_q <= '0;
      wb_tmr_q    <= '0;
      wb_adr_q    <= '0;
      wb_dat_q    <= '0;
      wb_sel_q    <= 4'h0;
      wb_we_q     <= 1'b0;
      wb_cyc_q    <= 1'b0;
      wb_stb_q    <= 1'b0;
      resp_sh_q   <= '0;
      resp_left_q <= '0;
      tx_rest_q   <= '1;
      tx_bit_q    <= '0;
      tx_cnt_q    <= '0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      byte_cnt_q  <= byte_cnt_d;
      sh_q        <= sh_d;
      adr_hold_q  <= adr_hold_d;
      frame_tmr_q <= frame_tmr_d;
      wb_tmr_q    <= wb_tmr_d;
      wb_adr_q    <= wb_adr_d;
      wb_dat_q    <= wb_dat_d;
      wb_sel_q    <= wb_sel_d;
      wb_we_q     <= wb_we_d;
      wb_cyc_q    <= wb_cyc_d;
      wb_stb_q    <= wb_stb_d;
      resp_sh_q   <= resp_sh_d;
      resp_left_q <= resp_left_d;
      tx_rest_q   <= tx_rest_d;
      tx_bit_q    <= tx_bit_d;
      tx_cnt_q    <= tx_cnt_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
    end
  end

  assign wb.wb_adr_o = wb_adr_q;
  assign wb.wb_dat_o = wb_dat_q;
  assign wb.wb_sel_o = wb_sel_q;
  assign wb.wb_we_o  = wb_we_q;
  assign wb.wb_cyc_o = wb_cyc_q;
  assign wb.wb_stb_o = wb_stb_q;
  assign uart_txd    = txd_q;
  assign busy        = busy_q;

endmodule
